// File: rtl/execute_stage.sv
// MIPS execute stage: operand forwarding, ALU, iterative MULTU/DIVU with HI/LO,
// and the EX/MEM pipeline register feeding the memory stage.
module execute_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int MD_CYCLES  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] RD1_E,
  input  logic [DATA_WIDTH-1:0] RD2_E,
  input  logic [DATA_WIDTH-1:0] signImm_E,
  input  logic [DATA_WIDTH-1:0] result_W,
  input  logic [1:0]            forwardA_E,
  input  logic [1:0]            forwardB_E,
  input  logic [2:0]            ALUControl_E,
  input  logic                  ALUSrc_E,
  input  logic                  regDst_E,
  input  logic [4:0]            rt_E,
  input  logic [4:0]            rd_E,
  input  logic                  regWrite_E,
  input  logic                  memWrite_E,
  input  logic                  memToReg_E,
  input  logic [1:0]            resultSel_E,
  input  logic                  mdStart_E,
  input  logic                  mdOp_E,
  output logic [DATA_WIDTH-1:0] ALU_out_M,
  output logic [DATA_WIDTH-1:0] writeData_M,
  output logic [4:0]            writeReg_M,
  output logic                  regWrite_M,
  output logic                  memWrite_M,
  output logic                  memToReg_M,
  output logic                  md_stall_E,
  output logic                  md_busy
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(MD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(MD_CYCLES);

  logic [DW-1:0] src_a, fwd_b, src_b, alu_y, ex_result;

  logic [DW-1:0] alu_m_q, wdata_m_q;
  logic [4:0]    wreg_m_q;
  logic          regwr_m_q, memwr_m_q, memtoreg_m_q;

  logic [DW-1:0] hi_q, lo_q;
  logic [DW-1:0] acc_q, wrk_q, opnd_q;
  logic [DW-1:0] acc_d, wrk_d;
  logic [CW-1:0] cnt_q;
  logic          op_q, busy_q;

  logic [DW:0]   mul_sum;
  logic [DW:0]   rem_sh;
  logic          div_ge;
  logic          md_accept;

  always_comb begin
    case (forwardA_E)
      2'b01:   src_a = result_W;
      2'b10:   src_a = alu_m_q;
      default: src_a = RD1_E;
    endcase
    case (forwardB_E)
      2'b01:   fwd_b = result_W;
      2'b10:   fwd_b = alu_m_q;
      default: fwd_b = RD2_E;
    endcase
    src_b = ALUSrc_E ? signImm_E : fwd_b;
  end

  always_comb begin
    alu_y = '0;
    case (ALUControl_E)
      3'b000: alu_y = src_a & src_b;
      3'b001: alu_y = src_a | src_b;
      3'b010: alu_y = src_a + src_b;
      3'b011: alu_y = src_a ^ src_b;
      3'b100: alu_y = ~(src_a | src_b);
      3'b110: alu_y = src_a - src_b;
      3'b111: alu_y = {{(DW-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      3'b101: alu_y = {{(DW-1){1'b0}}, (src_a < src_b)};
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    case (resultSel_E)
      2'b01:   ex_result = hi_q;
      2'b10:   ex_result = lo_q;
      default: ex_result = alu_y;
    endcase
  end

  assign md_stall_E = busy_q & (mdStart_E | (resultSel_E == 2'b01) | (resultSel_E == 2'b10));
  assign md_accept  = mdStart_E & ~busy_q;

  // acc holds the product's upper half (MULTU) or the partial remainder (DIVU);
  // wrk shifts out multiplier bits / dividend bits and shifts in low product / quotient bits.
  always_comb begin
    mul_sum = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh  = {acc_q, wrk_q[DW-1]};
    div_ge  = rem_sh >= {1'b0, opnd_q};
    if (op_q) begin
      acc_d = div_ge ? (rem_sh[DW-1:0] - opnd_q) : rem_sh[DW-1:0];
      wrk_d = {wrk_q[DW-2:0], div_ge};
    end else begin
      acc_d = mul_sum[DW:1];
      wrk_d = {mul_sum[0], wrk_q[DW-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      acc_q  <= '0;
      wrk_q  <= '0;
      opnd_q <= '0;
      op_q   <= 1'b0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (busy_q) begin
      acc_q <= acc_d;
      wrk_q <= wrk_d;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_q <= 1'b0;
        hi_q   <= acc_d;
        lo_q   <= wrk_d;
      end
    end else if (md_accept) begin
      acc_q  <= '0;
      wrk_q  <= src_a;
      opnd_q <= fwd_b;
      op_q   <= mdOp_E;
      cnt_q  <= CNT_INIT;
      busy_q <= 1'b1;
    end
  end

  // A stalled instruction stays in E, so M receives a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_m_q      <= '0;
      wdata_m_q    <= '0;
      wreg_m_q     <= '0;
      regwr_m_q    <= 1'b0;
      memwr_m_q    <= 1'b0;
      memtoreg_m_q <= 1'b0;
    end else if (md_stall_E) begin
      alu_m_q      <= '0;
      wdata_m_q    <= '0;
      wreg_m_q     <= '0;
      regwr_m_q    <= 1'b0;
      memwr_m_q    <= 1'b0;
      memtoreg_m_q <= 1'b0;
    end else begin
      alu_m_q      <= ex_result;
      wdata_m_q    <= fwd_b;
      wreg_m_q     <= regDst_E ? rd_E : rt_E;
      regwr_m_q    <= regWrite_E;
      memwr_m_q    <= memWrite_E;
      memtoreg_m_q <= memToReg_E;
    end
  end

  assign ALU_out_M   = alu_m_q;
  assign writeData_M = wdata_m_q;
  assign writeReg_M  = wreg_m_q;
  assign regWrite_M  = regwr_m_q;
  assign memWrite_M  = memwr_m_q;
  assign memToReg_M  = memtoreg_m_q;
  assign md_busy     = busy_q;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed scenarios plus random traffic, checked
// cycle by cycle against an arithmetic reference model of the stage.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] RD1_E, RD2_E, signImm_E, result_W;
  logic [1:0]  forwardA_E, forwardB_E, resultSel_E;
  logic [2:0]  ALUControl_E;
  logic        ALUSrc_E, regDst_E, regWrite_E, memWrite_E, memToReg_E;
  logic [4:0]  rt_E, rd_E;
  logic        mdStart_E, mdOp_E;
  logic [31:0] ALU_out_M, writeData_M;
  logic [4:0]  writeReg_M;
  logic        regWrite_M, memWrite_M, memToReg_M, md_stall_E, md_busy;

  always #5 clk = ~clk;

  execute_stage #(.DATA_WIDTH(32), .MD_CYCLES(32)) dut (
    .clk(clk), .reset(reset),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .signImm_E(signImm_E), .result_W(result_W),
    .forwardA_E(forwardA_E), .forwardB_E(forwardB_E),
    .ALUControl_E(ALUControl_E), .ALUSrc_E(ALUSrc_E), .regDst_E(regDst_E),
    .rt_E(rt_E), .rd_E(rd_E), .regWrite_E(regWrite_E), .memWrite_E(memWrite_E),
    .memToReg_E(memToReg_E), .resultSel_E(resultSel_E),
    .mdStart_E(mdStart_E), .mdOp_E(mdOp_E),
    .ALU_out_M(ALU_out_M), .writeData_M(writeData_M), .writeReg_M(writeReg_M),
    .regWrite_M(regWrite_M), .memWrite_M(memWrite_M), .memToReg_M(memToReg_M),
    .md_stall_E(md_stall_E), .md_busy(md_busy)
  );

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [31:0] m_alu, m_wd, m_hi, m_lo, p_hi, p_lo;
  logic [4:0]  m_wr;
  logic        m_rw, m_mw, m_mr, m_busy;
  int          m_left;
  logic        last_stall;
  int          busy_n, stall_n;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a + b;
      3'd3: return a ^ b;
      3'd4: return ~(a | b);
      3'd6: return a - b;
      3'd7: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      default: return (a < b) ? 32'd1 : 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_alu = 0; m_wd = 0; m_wr = 0; m_rw = 0; m_mw = 0; m_mr = 0;
    m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; m_busy = 0; m_left = 0;
  endtask

  task automatic nop();
    RD1_E = 0; RD2_E = 0; signImm_E = 0; result_W = 0;
    forwardA_E = 0; forwardB_E = 0; ALUControl_E = 3'd2; ALUSrc_E = 0;
    regDst_E = 0; rt_E = 0; rd_E = 0; regWrite_E = 0; memWrite_E = 0;
    memToReg_E = 0; resultSel_E = 0; mdStart_E = 0; mdOp_E = 0;
  endtask

  // One clock: predict stall and next M state from current inputs, then check.
  task automatic cycle();
    logic [31:0] a, fb, b, res;
    logic st;
    logic [63:0] prod;
    #1;
    a  = (forwardA_E == 2'd1) ? result_W : (forwardA_E == 2'd2) ? m_alu : RD1_E;
    fb = (forwardB_E == 2'd1) ? result_W : (forwardB_E == 2'd2) ? m_alu : RD2_E;
    b  = ALUSrc_E ? signImm_E : fb;
    st = m_busy && (mdStart_E || resultSel_E == 2'd1 || resultSel_E == 2'd2);
    chk("stall", md_stall_E, st);
    last_stall = md_stall_E;
    res = (resultSel_E == 2'd1) ? m_hi : (resultSel_E == 2'd2) ? m_lo : alu_ref(ALUControl_E, a, b);
    @(posedge clk); #1;
    if (st) begin
      m_alu = 0; m_wd = 0; m_wr = 0; m_rw = 0; m_mw = 0; m_mr = 0;
    end else begin
      m_alu = res; m_wd = fb; m_wr = regDst_E ? rd_E : rt_E;
      m_rw = regWrite_E; m_mw = memWrite_E; m_mr = memToReg_E;
    end
    if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_hi = p_hi; m_lo = p_lo; m_busy = 0;
      end
    end else if (mdStart_E) begin
      m_busy = 1; m_left = 32;
      if (!mdOp_E) begin
        prod = {32'd0, a} * {32'd0, fb};
        p_hi = prod[63:32]; p_lo = prod[31:0];
      end else if (fb == 0) begin
        p_lo = 32'hFFFF_FFFF; p_hi = a;
      end else begin
        p_lo = a / fb; p_hi = a % fb;
      end
    end
    chk("alu_out_m", ALU_out_M, m_alu);
    chk("write_data_m", writeData_M, m_wd);
    chk("ctl_m", {writeReg_M, regWrite_M, memWrite_M, memToReg_M}, {m_wr, m_rw, m_mw, m_mr});
    chk("md_busy", md_busy, m_busy);
    if (md_busy) busy_n++;
  endtask

  task automatic md_wait();
    int n = 0;
    while (m_busy && n < 40) begin
      nop(); cycle(); n++;
    end
    chk("md_wait_bound", md_busy, 1'b0);
  endtask

  task automatic start_md(input logic op, input logic [31:0] a, input logic [31:0] b);
    nop(); RD1_E = a; RD2_E = b; mdStart_E = 1; mdOp_E = op; cycle();
  endtask

  task automatic read_hilo(input logic [1:0] sel, input logic [31:0] exp, input string tag);
    nop(); resultSel_E = sel; regDst_E = 1; rd_E = 5'd9; regWrite_E = 1; cycle();
    chk(tag, ALU_out_M, exp);
  endtask

  initial begin
    nop();
    model_reset();
    reset = 1;
    #12;
    chk("reset_alu", ALU_out_M, 32'd0);
    chk("reset_ctl", {writeData_M, writeReg_M, regWrite_M, memWrite_M, memToReg_M, md_busy}, 0);
    #1 reset = 0;
    @(posedge clk); #1;

    // forwarding from M and compares
    nop(); RD1_E = 2; RD2_E = 3; regWrite_E = 1; cycle();
    chk("t1_setup", ALU_out_M, 32'd5);
    nop(); forwardA_E = 2'b10; RD1_E = 32'hDEAD; RD2_E = 3; cycle();
    chk("t1_fwd_add", ALU_out_M, 32'd8);
    nop(); ALUControl_E = 3'b111; RD1_E = 32'hFFFF_FFFF; RD2_E = 1; cycle();
    chk("t1_slt", ALU_out_M, 32'd1);
    nop(); ALUControl_E = 3'b101; RD1_E = 32'hFFFF_FFFF; RD2_E = 1; cycle();
    chk("t1_sltu", ALU_out_M, 32'd0);

    // store path
    nop(); memWrite_E = 1; ALUSrc_E = 1; signImm_E = 4; RD1_E = 32'h100; RD2_E = 32'hABCD; cycle();
    chk("t2_addr", ALU_out_M, 32'h104);
    chk("t2_wdata", writeData_M, 32'hABCD);
    chk("t2_memwrite", memWrite_M, 1'b1);

    // MULTU, then an unrelated ADD while busy, then MFLO which stalls
    busy_n = 0; stall_n = 0;
    start_md(1'b0, 32'hFFFF_FFFF, 32'd2);
    nop(); RD1_E = 10; RD2_E = 20; regWrite_E = 1; rd_E = 3; regDst_E = 1; cycle();
    chk("t5_add_while_busy", ALU_out_M, 32'd30);
    nop(); resultSel_E = 2'b10; regDst_E = 1; rd_E = 5'd7; regWrite_E = 1;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (!last_stall) break;
      stall_n++;
      chk("t3_bubble", {ALU_out_M, regWrite_M}, 0);
    end
    chk("t3_stall_cycles", stall_n, 31);
    chk("t3_busy_cycles", busy_n, 32);
    chk("t3_mflo", ALU_out_M, 32'hFFFF_FFFE);
    read_hilo(2'b01, 32'h0000_0001, "t3_mfhi");

    // DIVU, including divide by zero
    start_md(1'b1, 32'd100, 32'd7);
    md_wait();
    read_hilo(2'b10, 32'd14, "t4_div_lo");
    read_hilo(2'b01, 32'd2, "t4_div_hi");
    start_md(1'b1, 32'd9, 32'd0);
    md_wait();
    read_hilo(2'b10, 32'hFFFF_FFFF, "t4_div0_lo");
    read_hilo(2'b01, 32'd9, "t4_div0_hi");

    // reset part-way through a MULTU
    start_md(1'b0, 32'h1234_5678, 32'd9);
    for (int i = 0; i < 10; i++) begin nop(); ALUControl_E = 3'd1; RD1_E = 32'h55; rt_E = 5'd4; regWrite_E = 1; cycle(); end
    #2 reset = 1;
    #1;
    chk("t6_busy", md_busy, 1'b0);
    chk("t6_m_outs", {ALU_out_M, writeData_M, writeReg_M, regWrite_M, memWrite_M, memToReg_M}, 0);
    model_reset();
    #2 reset = 0;
    @(posedge clk); #1;
    read_hilo(2'b10, 32'd0, "t6_lo_cleared");
    read_hilo(2'b01, 32'd0, "t6_hi_cleared");
    start_md(1'b1, 32'd20, 32'd3);
    md_wait();
    read_hilo(2'b10, 32'd6, "t6_div_lo");
    read_hilo(2'b01, 32'd2, "t6_div_hi");

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      RD1_E = $urandom; RD2_E = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      signImm_E = $urandom; result_W = $urandom;
      forwardA_E = 2'($urandom_range(0, 3)); forwardB_E = 2'($urandom_range(0, 3));
      ALUControl_E = 3'($urandom_range(0, 7)); ALUSrc_E = 1'($urandom_range(0, 1));
      regDst_E = 1'($urandom_range(0, 1)); rt_E = 5'($urandom_range(0, 31)); rd_E = 5'($urandom_range(0, 31));
      regWrite_E = 1'($urandom_range(0, 1)); memWrite_E = 1'($urandom_range(0, 1));
      memToReg_E = 1'($urandom_range(0, 1)); resultSel_E = 2'($urandom_range(0, 3));
      mdStart_E = ($urandom_range(0, 11) == 0); mdOp_E = 1'($urandom_range(0, 1));
      cycle();
    end
    nop();
    md_wait();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
